// File: rtl/cv32e40p_obi_pkg.sv
// Shared types and helpers for the OBI memory responder.
package cv32e40p_obi_pkg;

  // Response payload carried alongside the valid bit through the pipeline.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_resp_t;

  // Read data returned for an access that misses the memory window.
  localparam logic [31:0] OBI_ERR_RDATA = 32'hDEAD_BEEF;

  // Merge a write into an existing word, replacing only enabled bytes.
  function automatic logic [31:0] obi_be_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_pipe.sv
// Fixed-length delay line for response valid + payload with synchronous clear.
// Payload is zeroed in any stage whose valid is low, so the output payload is
// all-zero whenever the output valid is low.
module cv32e40p_obi_resp_pipe
  import cv32e40p_obi_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_valid,
  input  obi_resp_t push_resp,
  output logic      pop_valid,
  output obi_resp_t pop_resp
);

  logic      valid_q [LATENCY];
  obi_resp_t resp_q  [LATENCY];

  // Shift every stage by one each cycle; clear drops all in-flight entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        resp_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= push_valid;
      resp_q[0]  <= push_valid ? push_resp : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        resp_q[i]  <= resp_q[i-1];
      end
    end
  end

  assign pop_valid = valid_q[LATENCY-1];
  assign pop_resp  = resp_q[LATENCY-1];

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// Memory-side OBI responder: word-addressed SRAM model with byte-enable
// writes, fixed response latency and a bounded outstanding count.
//
// Handshake: a transaction is accepted at the rising edge where req_i && gnt_o.
// gnt_o is combinational from req_i, stall_i, rst_i and the outstanding count.
// Each accept produces exactly one rvalid_o pulse LATENCY cycles later, in
// order; rvalid_o has no back-pressure. rdata_o/err_o are zero unless rvalid_o.
module cv32e40p_obi_mem_responder
  import cv32e40p_obi_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_RDATA       = OBI_ERR_RDATA
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_i,
  output logic                                 gnt_o,
  input  logic [31:0]                          addr_i,
  input  logic                                 we_i,
  input  logic [3:0]                           be_i,
  input  logic [31:0]                          wdata_i,
  input  logic                                 stall_i,
  output logic                                 rvalid_o,
  output logic [31:0]                          rdata_o,
  output logic                                 err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int unsigned CW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  logic [31:0]   mem [MEM_WORDS];
  logic [CW-1:0] cnt_q;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          accept;
  logic          pipe_valid;
  obi_resp_t     pipe_resp;
  obi_resp_t     new_resp;

  // Unsigned wrap makes addresses below BASE_ADDR land out of range.
  assign offset   = addr_i - BASE_ADDR;
  assign in_range = offset < MEM_BYTES;
  assign idx      = offset[AW+1:2];

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign gnt_o  = req_i && !stall_i && !rst_i && ((cnt_q - CW'(pipe_valid)) < MAX_OUT);
  assign accept = req_i && gnt_o;

  // Build the response: reads sample the array before any write at this edge.
  always_comb begin
    new_resp       = '0;
    new_resp.err   = !in_range;
    if (!we_i) new_resp.rdata = in_range ? mem[idx] : ERR_RDATA;
  end

  // Commit in-range writes at the accept edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) mem[idx] <= obi_be_merge(mem[idx], wdata_i, be_i);
  end

  // Outstanding count: +1 on accept, -1 on response, unchanged when both.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      case ({accept, pipe_valid})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  cv32e40p_obi_resp_pipe #(.LATENCY(LATENCY)) u_resp_pipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_valid (accept),
    .push_resp  (new_resp),
    .pop_valid  (pipe_valid),
    .pop_resp   (pipe_resp)
  );

  assign rvalid_o      = pipe_valid;
  assign rdata_o       = pipe_resp.rdata;
  assign err_o         = pipe_resp.err;
  assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Directed bench: instance 0 uses LATENCY=1, instance 1 uses LATENCY=3 with a
// small window at a non-zero base address.
module tb_cv32e40p_obi_mem_responder;

  localparam logic [31:0] B_BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst    [2];
  logic        req    [2];
  logic        gnt    [2];
  logic [31:0] addr   [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] wdata  [2];
  logic        stall  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];
  logic [1:0]  outst  [2];

  int n_checks = 0;
  int n_err    = 0;
  int lat_exp [2] = '{1, 3};
  logic [31:0] exp_q [$];

  // Clock / reset block.
  always #5 clk = ~clk;

  cv32e40p_obi_mem_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)
  ) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .gnt_o(gnt[0]),
    .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
    .stall_i(stall[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .outstanding_o(outst[0])
  );

  cv32e40p_obi_mem_responder #(
    .MEM_WORDS(16), .BASE_ADDR(B_BASE), .LATENCY(3), .MAX_OUTSTANDING(2)
  ) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .gnt_o(gnt[1]),
    .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
    .stall_i(stall[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .outstanding_o(outst[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: one transaction, wait for grant, then for the response.
  task automatic xact(input int d, input string tag, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_e);
    int waited;
    int lat;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    #1;
    waited = 0;
    while (!gnt[d] && waited < 10) begin
      @(negedge clk); #1; waited++;
    end
    check({tag, "_gnt"}, 32'(gnt[d]), 32'd1);
    @(negedge clk);
    req[d] = 1'b0;
    #1;
    lat = 1;
    while (!rvalid[d] && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp[d]));
    check({tag, "_rdata"}, rdata[d], exp_rd);
    check({tag, "_err"}, 32'(err[d]), 32'(exp_e));
  endtask

  initial begin : main
    bit [7:0] exp_gnt;
    bit [7:0] exp_rv;
    int       exp_out [8];
    int       issued;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b1; we[d] = 1'b0; addr[d] = '0;
      be[d] = 4'hF; wdata[d] = '0; stall[d] = 1'b0;
    end

    // Reset state, and grant held off while reset is high.
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_gnt", 32'(gnt[d]), 32'd0);
      check("rst_rvalid", 32'(rvalid[d]), 32'd0);
      check("rst_rdata", rdata[d], 32'd0);
      check("rst_err", 32'(err[d]), 32'd0);
      check("rst_outst", 32'(outst[d]), 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req[d] = 1'b0;
    end

    // 1: basic write then read.
    xact(0, "t1_wr", 1'b1, 32'h10, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
    xact(0, "t1_rd", 1'b0, 32'h10, 4'hF, 32'h0, 32'h1234_5678, 1'b0);

    // 2: byte-enable merge.
    xact(0, "t2_init", 1'b1, 32'h20, 4'hF, 32'h1111_1111, 32'h0, 1'b0);
    xact(0, "t2_wr", 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0);
    xact(0, "t2_rd", 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB_11DD, 1'b0);
    xact(0, "t2_be0", 1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    xact(0, "t2_rd0", 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB_11DD, 1'b0);

    // 3: out-of-range read and write; memory untouched.
    xact(0, "t3_rd_oor", 1'b0, 32'h1000, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
    xact(0, "t3_wr_oor", 1'b1, 32'hFFFF_FFFC, 4'hF, 32'h9999_9999, 32'h0, 1'b1);
    xact(0, "t3_rd_chk", 1'b0, 32'h10, 4'hF, 32'h0, 32'h1234_5678, 1'b0);
    xact(1, "t3b_rd_oor", 1'b0, B_BASE + 32'h40, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
    xact(1, "t3b_wr_low", 1'b1, B_BASE - 32'h4, 4'hF, 32'h1, 32'h0, 1'b1);

    // Read-after-write in consecutive accepts returns the new word.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; be[0] = 4'hF; wdata[0] = 32'hA5A5_0001;
    #1;
    check("raw_wr_gnt", 32'(gnt[0]), 32'd1);
    @(negedge clk);
    we[0] = 1'b0;
    #1;
    check("raw_rd_gnt", 32'(gnt[0]), 32'd1);
    check("raw_wr_rvalid", 32'(rvalid[0]), 32'd1);
    check("raw_wr_rdata", rdata[0], 32'h0);
    @(negedge clk);
    req[0] = 1'b0;
    #1;
    check("raw_rd_rvalid", 32'(rvalid[0]), 32'd1);
    check("raw_rd_rdata", rdata[0], 32'hA5A5_0001);
    @(negedge clk);
    #1;
    check("raw_idle_rvalid", 32'(rvalid[0]), 32'd0);
    check("raw_idle_rdata", rdata[0], 32'h0);

    // 4: LATENCY=3, MAX_OUTSTANDING=2 with back-to-back reads.
    for (int i = 0; i < 4; i++)
      xact(1, "t4_fill", 1'b1, B_BASE + 32'(i * 4), 4'hF, 32'hB000_0000 + 32'(i), 32'h0, 1'b0);
    xact(1, "t4_fill3", 1'b1, B_BASE + 32'hC, 4'hF, 32'h600D_F00D, 32'h0, 1'b0);
    exp_gnt = 8'b0000_1011;
    exp_rv  = 8'b0101_1000;
    exp_out = '{0, 1, 2, 2, 2, 1, 1, 0};
    issued  = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req[1] = (issued < 3); we[1] = 1'b0; addr[1] = B_BASE + 32'(issued * 4);
      #1;
      check($sformatf("t4_gnt_c%0d", c), 32'(gnt[1]), 32'(exp_gnt[c]));
      check($sformatf("t4_rvalid_c%0d", c), 32'(rvalid[1]), 32'(exp_rv[c]));
      check($sformatf("t4_outst_c%0d", c), 32'(outst[1]), 32'(exp_out[c]));
      if (rvalid[1] && exp_q.size() > 0) check("t4_rdata", rdata[1], exp_q.pop_front());
      if (gnt[1]) begin
        exp_q.push_back(32'hB000_0000 + 32'(issued));
        issued++;
      end
    end
    req[1] = 1'b0;
    check("t4_drain", 32'(exp_q.size()), 32'd0);

    // 5: stall holds off a write; after release a read sees old data.
    xact(0, "t5_init", 1'b1, 32'h30, 4'hF, 32'h7777_0000, 32'h0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h5555_5555; stall[0] = 1'b1;
      #1;
      check($sformatf("t5_stall_gnt_c%0d", c), 32'(gnt[0]), 32'd0);
      check($sformatf("t5_stall_rvalid_c%0d", c), 32'(rvalid[0]), 32'd0);
    end
    @(negedge clk);
    stall[0] = 1'b0; we[0] = 1'b0;
    #1;
    check("t5_release_gnt", 32'(gnt[0]), 32'd1);
    @(negedge clk);
    req[0] = 1'b0;
    #1;
    check("t5_rvalid", 32'(rvalid[0]), 32'd1);
    check("t5_rdata", rdata[0], 32'h7777_0000);

    // 6: reset with two reads in flight on the LATENCY=3 instance.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = B_BASE + 32'(c * 4);
      #1;
      check($sformatf("t6_gnt_c%0d", c), 32'(gnt[1]), 32'd1);
    end
    @(negedge clk);
    req[1] = 1'b0; rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0; req[1] = 1'b1; addr[1] = B_BASE + 32'hC;
    #1;
    check("t6_resume_gnt", 32'(gnt[1]), 32'd1);
    check("t6_rvalid_c3", 32'(rvalid[1]), 32'd0);
    check("t6_outst_c3", 32'(outst[1]), 32'd0);
    @(negedge clk);
    req[1] = 1'b0;
    #1;
    check("t6_rvalid_c4", 32'(rvalid[1]), 32'd0);
    check("t6_outst_c4", 32'(outst[1]), 32'd1);
    @(negedge clk);
    #1;
    check("t6_rvalid_c5", 32'(rvalid[1]), 32'd0);
    @(negedge clk);
    #1;
    check("t6_rvalid_c6", 32'(rvalid[1]), 32'd1);
    check("t6_rdata_c6", rdata[1], 32'h600D_F00D);
    check("t6_err_c6", 32'(err[1]), 32'd0);
    @(negedge clk);
    #1;
    check("t6_rvalid_c7", 32'(rvalid[1]), 32'd0);
    check("t6_outst_c7", 32'(outst[1]), 32'd0);
    xact(1, "t6_persist", 1'b0, B_BASE, 4'hF, 32'h0, 32'hB000_0000, 1'b0);

    // Final report.
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
